// File: rtl/hazard_unit_nstage_if.sv
// Bundle between the N-stage pipeline and its hazard controller.
// The pipeline side is the master; the hazard unit is the slave.
interface hazard_unit_nstage_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 32
);
  logic                  i_ram_busy;
  logic                  d_ram_busy;
  logic                  iren;
  logic                  dren;
  logic                  dwen;
  logic                  jump;
  logic                  branch;
  logic                  mispredict;
  logic                  halt;
  logic                  pc_en;
  logic                  npc_sel;
  logic [NUM_STAGES-1:0] stall;
  logic [NUM_STAGES-1:0] flush;
  logic                  halted;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output i_ram_busy, d_ram_busy, iren, dren, dwen, jump, branch, mispredict, halt,
    input  pc_en, npc_sel, stall, flush, halted, mem_timeout, stall_count
  );

  modport slave (
    input  i_ram_busy, d_ram_busy, iren, dren, dwen, jump, branch, mispredict, halt,
    output pc_en, npc_sel, stall, flush, halted, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_unit_nstage.sv
// Parametrised stall/flush controller for the N-stage pipeline with a data-memory watchdog.
// Optional stall cycle counter enabled by defining STALL_COUNTER_EN.
module hazard_unit_nstage #(
  parameter int NUM_STAGES    = 3,
  parameter int RESOLVE_STAGE = NUM_STAGES - 1,
  parameter int MEM_TIMEOUT   = 1024,
  parameter int CNT_W         = 32
) (
  input logic                 CLK,
  input logic                 nRST,
  hazard_unit_nstage_if.slave bus
);

  typedef enum logic [1:0] {RUN, DWAIT, HALTING, HALTED} state_e;

  localparam int WD_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MEM_TIMEOUT);
  // The resolve stage itself is only flushed when a later stage exists to receive its slot.
  localparam int FLUSH_CNT = (RESOLVE_STAGE < NUM_STAGES - 1) ? RESOLVE_STAGE + 1 : RESOLVE_STAGE;
  localparam logic [NUM_STAGES-1:0] REDIRECT_FLUSH = NUM_STAGES'((64'd1 << FLUSH_CNT) - 64'd1);

  state_e                state_q, state_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  timeout_q, timeout_d;
  logic                  redirect, dmem, runRules;
  logic                  pcEn, npcSel;
  logic [NUM_STAGES-1:0] stall, flush;

  assign redirect = bus.jump | bus.mispredict | (bus.branch & bus.mispredict);
  assign dmem     = bus.dren | bus.dwen;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q   <= RUN;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;
    pcEn      = 1'b0;
    npcSel    = 1'b0;
    stall     = '1;
    flush     = '0;
    runRules  = 1'b0;

    case (state_q)
      RUN: begin
        if (dmem && bus.d_ram_busy) state_d = DWAIT;
        else                        runRules = 1'b1;
      end
      DWAIT: begin
        if (bus.d_ram_busy) begin
          if (wd_q != WD_MAX) wd_d = wd_q + 1'b1;
          if (wd_d == WD_MAX) timeout_d = 1'b1;
        end else begin
          wd_d     = '0;
          runRules = 1'b1;
        end
      end
      HALTING: begin
        if (!(dmem && bus.d_ram_busy)) state_d = HALTED;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = RUN;
    endcase

    // Shared by normal RUN cycles and the DWAIT release cycle, so a held redirect is taken on release.
    if (runRules) begin
      state_d = RUN;
      if (bus.halt) begin
        state_d = HALTING;
      end else if (redirect) begin
        pcEn   = 1'b1;
        npcSel = 1'b1;
        stall  = '0;
        flush  = REDIRECT_FLUSH;
      end else if (bus.iren && bus.i_ram_busy) begin
        stall    = '0;
        stall[0] = 1'b1;
        flush[1] = 1'b1;
      end else begin
        pcEn  = 1'b1;
        stall = '0;
      end
    end

    if (!nRST) begin
      pcEn   = 1'b0;
      npcSel = 1'b0;
      stall  = '1;
      flush  = '0;
    end
  end

  assign bus.pc_en       = pcEn;
  assign bus.npc_sel     = npcSel;
  assign bus.stall       = stall;
  assign bus.flush       = flush;
  assign bus.halted      = (state_q == HALTED);
  assign bus.mem_timeout = timeout_q;

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stallCount_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stallCount_q <= '0;
    end else if (stall[0] && (state_q != HALTED)) begin
      stallCount_q <= stallCount_q + 1'b1;
    end
  end

  assign bus.stall_count = stallCount_q;
`else
  assign bus.stall_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit_nstage.sv
// Scoreboard bench for hazard_unit_nstage (3 stages, resolve in stage 2, watchdog of 8 cycles).
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares them.
module tb_hazard_unit_nstage;

  // Expected vector: {pc_en, npc_sel, stall[2:0], flush[2:0], halted, mem_timeout}
  localparam logic [9:0] E_RST      = 10'b0_0_111_000_0_0;
  localparam logic [9:0] E_RUN      = 10'b1_0_000_000_0_0;
  localparam logic [9:0] E_IWAIT    = 10'b0_0_001_010_0_0;
  localparam logic [9:0] E_REDIR    = 10'b1_1_000_011_0_0;
  localparam logic [9:0] E_HOLD     = 10'b0_0_111_000_0_0;
  localparam logic [9:0] E_HOLD_TO  = 10'b0_0_111_000_0_1;
  localparam logic [9:0] E_RUN_TO   = 10'b1_0_000_000_0_1;
  localparam logic [9:0] E_HALTED   = 10'b0_0_111_000_1_1;

  logic clk = 1'b0;
  logic nRST;
  int   testsRun = 0;
  int   testsFailed = 0;
  logic [9:0] expQ[$];
  string      nameQ[$];

  always #5 clk = ~clk;

  hazard_unit_nstage_if #(.NUM_STAGES(3), .CNT_W(16)) hif();

  hazard_unit_nstage #(
    .NUM_STAGES(3),
    .RESOLVE_STAGE(2),
    .MEM_TIMEOUT(8),
    .CNT_W(16)
  ) dut (
    .CLK(clk),
    .nRST(nRST),
    .bus(hif)
  );

  // Input vector: {nRST, i_ram_busy, d_ram_busy, iren, dren, dwen, jump, branch, mispredict, halt}
  task automatic applyStimulus(input logic [9:0] vec, input logic [9:0] exp, input string name);
    @(posedge clk);
    #1;
    {nRST, hif.i_ram_busy, hif.d_ram_busy, hif.iren, hif.dren, hif.dwen,
     hif.jump, hif.branch, hif.mispredict, hif.halt} = vec;
    expQ.push_back(exp);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput();
    logic [9:0] exp;
    logic [9:0] act;
    string      name;
    exp  = expQ.pop_front();
    name = nameQ.pop_front();
    act  = {hif.pc_en, hif.npc_sel, hif.stall, hif.flush, hif.halted, hif.mem_timeout};
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
`ifndef STALL_COUNTER_EN
    testsRun++;
    if (hif.stall_count !== 16'd0) begin
      testsFailed++;
      $display("[TB] FAIL %s stall_count: got %0d expected 0", name, hif.stall_count);
    end
`endif
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) checkOutput();
  end

  initial begin
    {nRST, hif.i_ram_busy, hif.d_ram_busy, hif.iren, hif.dren, hif.dwen,
     hif.jump, hif.branch, hif.mispredict, hif.halt} = 10'b0;

    applyStimulus(10'b0000000000, E_RST,   "reset0");
    applyStimulus(10'b0000000000, E_RST,   "reset1");
    applyStimulus(10'b1000000000, E_RUN,   "first_run");
    applyStimulus(10'b1101000000, E_IWAIT, "ifetch_wait");
    applyStimulus(10'b1101000010, E_REDIR, "mispredict_vs_ibusy");
    applyStimulus(10'b1000001000, E_REDIR, "jump");
    applyStimulus(10'b1000000100, E_RUN,   "branch_not_mispredicted");

    applyStimulus(10'b1010101000, E_HOLD,  "load_busy_with_jump");
    applyStimulus(10'b1010101000, E_HOLD,  "dwait_1");
    applyStimulus(10'b1010101000, E_HOLD,  "dwait_2");
    applyStimulus(10'b1000101000, E_REDIR, "dwait_release_redirect");
    applyStimulus(10'b1000000000, E_RUN,   "idle_after_load");

    applyStimulus(10'b1010010000, E_HOLD,  "store_busy_enter");
    for (int i = 0; i < 8; i++) applyStimulus(10'b1010010000, E_HOLD, "watchdog_counting");
    applyStimulus(10'b1010010000, E_HOLD_TO, "watchdog_fired");
    applyStimulus(10'b1000010000, E_RUN_TO,  "timeout_release");
    applyStimulus(10'b1000000000, E_RUN_TO,  "timeout_sticky");

    applyStimulus(10'b1010010001, E_HOLD_TO, "halt_store_busy");
    applyStimulus(10'b1010010001, E_HOLD_TO, "halt_dwait");
    applyStimulus(10'b1000010001, E_HOLD_TO, "halt_release");
    applyStimulus(10'b1010010000, E_HOLD_TO, "halting_wait_dmem");
    applyStimulus(10'b1000010000, E_HOLD_TO, "halting_done");
    for (int i = 0; i < 20; i++) applyStimulus({1'b1, 9'($urandom)}, E_HALTED, "halted_hold");

    applyStimulus(10'b0000000000, E_HALTED, "reset_from_halted");
    applyStimulus(10'b1000000000, E_RUN,    "run_after_halt_reset");

    applyStimulus(10'b1010100000, E_HOLD, "load_busy_again");
    applyStimulus(10'b1010100000, E_HOLD, "dwait_again");
    applyStimulus(10'b0010100000, E_HOLD, "reset_mid_dwait");
    applyStimulus(10'b1000000000, E_RUN,  "run_after_dwait_reset");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (expQ.size() > 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
